// File: rtl/trip_distance_accum.sv
`default_nettype none
// ============================================================================
// Module   : trip_distance_accum
// Purpose  : Integrates latched ground speed once per second into a saturating
//            0.01-mile trip counter and presents it as four BCD digits.
// Revision : 1.0
// ============================================================================
module trip_distance_accum #(
  parameter int CLK_FREQ_HZ   = 100000000,
  parameter int STALE_SEC     = 3,
  parameter int UNITS_PER_CNT = 3600,
  parameter int MAX_COUNT     = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        speed_ready,
  input  logic [15:0] mph_x100,
  input  logic        fix_valid,
  input  logic        clear,
  output logic [3:0]  dist0,
  output logic [3:0]  dist1,
  output logic [3:0]  dist2,
  output logic [3:0]  dist3,
  output logic [13:0] dist_x100,
  output logic        dist_update,
  output logic        busy
);

  localparam int                 TMR_W     = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam int                 STALE_W   = $clog2(STALE_SEC + 1);
  localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(CLK_FREQ_HZ - 1);
  localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_SEC);
  localparam logic [16:0]        UNITS     = 17'(UNITS_PER_CNT);
  localparam logic [13:0]        DIST_MAX  = 14'(MAX_COUNT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REDUCE = 2'd1,
    S_BCD    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [TMR_W-1:0]   timer;
  logic               sec_tick;
  logic [15:0]        spd_q;
  logic [STALE_W-1:0] stale_cnt;
  logic               pending;
  logic               clr_pend;
  logic [16:0]        frac;
  logic [13:0]        bin_sr;
  logic [15:0]        bcd_sr;
  logic [11:0]        bcd_adj;
  logic [3:0]         bit_cnt;
  logic               accum_ok;
  logic               service;
  logic               frac_ge;

  // One-second timebase; clear restarts the second.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      timer <= '0;
    end else if (timer == TMR_LAST) begin
      timer <= '0;
    end else begin
      timer <= timer + TMR_W'(1);
    end
  end

  assign sec_tick = (timer == TMR_LAST) && !clear;

  always_ff @(posedge clk) begin
    if (rst) begin
      spd_q     <= '0;
      stale_cnt <= STALE_MAX;
    end else if (speed_ready) begin
      spd_q     <= mph_x100;
      stale_cnt <= '0;
    end else if (sec_tick && (stale_cnt < STALE_MAX)) begin
      stale_cnt <= stale_cnt + STALE_W'(1);
    end
  end

  assign accum_ok = fix_valid && (stale_cnt < STALE_MAX);
  assign service  = sec_tick || pending;
  assign frac_ge  = (frac >= UNITS);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (service && accum_ok) state_nxt = S_REDUCE;
      S_REDUCE: if (!frac_ge) state_nxt = S_BCD;
      S_BCD:    if (bit_cnt == 4'd13) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // The thousands digit never reaches 5 for values up to 9999, so only the
  // lower three digits need the add-3 correction.
  always_comb begin
    bcd_adj = bcd_sr[11:0];
    for (int i = 0; i < 3; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      frac      <= '0;
      dist_x100 <= '0;
      pending   <= 1'b0;
      bin_sr    <= '0;
      bcd_sr    <= '0;
      bit_cnt   <= '0;
      dist0     <= '0;
      dist1     <= '0;
      dist2     <= '0;
      dist3     <= '0;
    end else begin
      if (state == S_IDLE) begin
        pending <= 1'b0;
      end else if (sec_tick) begin
        pending <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (service && accum_ok) begin
            frac <= frac + {1'b0, spd_q};
          end
        end
        S_REDUCE: begin
          if (frac_ge) begin
            frac <= frac - UNITS;
            if (dist_x100 < DIST_MAX) begin
              dist_x100 <= dist_x100 + 14'd1;
            end
          end else begin
            bin_sr  <= dist_x100;
            bcd_sr  <= '0;
            bit_cnt <= '0;
          end
        end
        S_BCD: begin
          bin_sr  <= {bin_sr[12:0], 1'b0};
          bcd_sr  <= {bcd_sr[14:12], bcd_adj, bin_sr[13]};
          bit_cnt <= bit_cnt + 4'd1;
        end
        S_DONE: begin
          dist0 <= bcd_sr[3:0];
          dist1 <= bcd_sr[7:4];
          dist2 <= bcd_sr[11:8];
          dist3 <= bcd_sr[15:12];
        end
        default: ;
      endcase
    end
  end

  // A clear announces the zeroed display once it is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      dist_update <= 1'b0;
      clr_pend    <= 1'b0;
    end else if (clear) begin
      dist_update <= 1'b0;
      clr_pend    <= 1'b1;
    end else begin
      dist_update <= (state == S_DONE) || clr_pend;
      clr_pend    <= 1'b0;
    end
  end

endmodule
`default_nettype wire
